lfsr_range_gen: RTL

LFSR_RANGE_GEN -- requirements
Module: lfsr_range_gen

---
 rtl/lfsr_range_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/lfsr_range_gen.sv
// XNOR Fibonacci LFSR whose masked state is rejection-sampled (with forced fold) into [OUT_MIN, OUT_MAX].
// Latency: a sample accepted at edge N is presented with o_Valid high right after edge N.
// Backpressure: o_Data holds while o_Valid && !i_Ready; the LFSR keeps running on i_Enable regardless.
module lfsr_range_gen #(
    parameter int               WIDTH        = 5,
    parameter logic [WIDTH-1:0] TAPS         = 5'b11000,
    parameter logic [WIDTH-1:0] SEED         = '0,
    parameter int               OUT_MIN      = 2,
    parameter int               OUT_MAX      = 19,
    parameter int               REJECT_LIMIT = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_Enable,
    input  logic             i_Seed_Load,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_Ready,
    output logic             o_Valid,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Fallback,
    output logic [WIDTH-1:0] o_State
);

    function automatic int calc_mask(input int span);
        int m;
        m = 0;
        for (int k = 0; k < 17; k++) begin
            if (m < span - 1) m = (m << 1) | 1;
        end
        return m;
    endfunction

    localparam int               SPAN    = OUT_MAX - OUT_MIN + 1;
    localparam logic [WIDTH-1:0] MASK    = WIDTH'(calc_mask(SPAN));
    // SPAN can reach 2^WIDTH, so range compares are done one bit wider
    localparam logic [WIDTH:0]   SPAN_W  = (WIDTH+1)'(SPAN);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(OUT_MIN);
    localparam logic [3:0]       LIMIT_W = 4'(REJECT_LIMIT);
    localparam logic [WIDTH-1:0] ONES    = '1;

    typedef enum logic {FILL, VALID} fsm_t;

    fsm_t             fsm;
    logic [WIDTH-1:0] state;
    logic [3:0]       count;
    logic             feedback;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] cand;
    logic             in_range;
    logic             limit_hit;
    logic [WIDTH-1:0] accept_val;
    logic [WIDTH-1:0] fold_val;
    logic [WIDTH:0]   fold_off;

    assign feedback   = ~^(state & TAPS);
    assign state_next = {state[WIDTH-2:0], feedback};
    assign cand       = state & MASK;
    assign in_range   = {1'b0, cand} < SPAN_W;
    assign limit_hit  = (count + 4'd1) == LIMIT_W;
    assign accept_val = MIN_W + cand;
    assign fold_off   = {1'b0, cand} - SPAN_W;
    assign fold_val   = MIN_W + fold_off[WIDTH-1:0];

    assign o_Valid = (fsm == VALID);
    assign o_State = state;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= SEED;
            fsm        <= FILL;
            count      <= 4'd0;
            o_Data     <= '0;
            o_Fallback <= 1'b0;
        end else begin
            o_Fallback <= 1'b0;
            if (i_Seed_Load) begin
                // all-ones would lock the XNOR LFSR, so fall back to SEED
                state <= (i_Seed == ONES) ? SEED : i_Seed;
                count <= 4'd0;
                fsm   <= FILL;
            end else begin
                if (i_Enable) state <= state_next;
                case (fsm)
                    FILL: begin
                        if (i_Enable) begin
                            if (in_range) begin
                                o_Data <= accept_val;
                                count  <= 4'd0;
                                fsm    <= VALID;
                            end else if (limit_hit) begin
                                o_Data     <= fold_val;
                                o_Fallback <= 1'b1;
                                count      <= 4'd0;
                                fsm        <= VALID;
                            end else begin
                                count <= count + 4'd1;
                            end
                        end
                    end
                    VALID: begin
                        if (i_Ready) fsm <= FILL;
                    end
                    default: fsm <= FILL;
                endcase
            end
        end
    end

endmodule
